multih_loop_acq_ctrl: RTL and testbench
=======================================

Name: multih_loop_acq_ctrl

Overview:
Acquisition/track sequencer for the multi-h trellis carrier loop. It drives the loop filter gain exponents and the accumulator/error clear controls from the demodulator lock indication. Each search uses wide-bandwidth acquisition gains and switches to narrow tracking gains once lock has been held for a programmed dwell. On sustained loss of lock, or an acquisition timeout, it clears the loop and restarts. It sits between the microprocessor register block and the carrier loop's leadExp/lagExp/clearAccum/zeroError inputs.

Parameters:
CLEAR_SYMS, 4, number of symEn strobes spent in CLEAR with accumulator and error zeroed (1..255)
CNT_W, 16, width of dwell/timeout counters and their limit ports

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
symEn  input  1  symbol-rate clock enable; all timers advance only on symEn
enable  input  1  controller run; 0 forces IDLE
demodLock  input  1  lock indication from carrier loop lock detector
acqLeadExp  input  5  lead exponent used in CLEAR/ACQ
acqLagExp  input  5  lag exponent used in CLEAR/ACQ
trkLeadExp  input  5  lead exponent used in TRACK
trkLagExp  input  5  lag exponent used in TRACK
dwellCount  input  CNT_W  consecutive locked symbols required in ACQ before TRACK (0 treated as 1)
lossCount  input  CNT_W  consecutive unlocked symbols in TRACK before reacquire (0 treated as 1)
acqTimeout  input  CNT_W  max symbols in ACQ before restart; 0 disables timeout
leadExp  output  5  to loop leadGain
lagExp  output  5  to loop lagGain
clearAccum  output  1  hold lag accumulator cleared
zeroError  output  1  force loop error to zero
state  output  2  0 IDLE, 1 CLEAR, 2 ACQ, 3 TRACK
trackLock  output  1  1 only in TRACK
reacqCount  output  8  number of restarts since leaving IDLE, saturates at 255

Behaviour:
- Reset: state=IDLE, all counters 0, leadExp=0, lagExp=0, clearAccum=1, zeroError=1, trackLock=0, reacqCount=0.
- All outputs are registered and decoded from the next state. They change on the same clk edge as state, with no extra lag.
- IDLE: clearAccum=1, zeroError=1, exps=acq values, trackLock=0. enable=1 -> CLEAR next cycle; reacqCount cleared to 0 on this transition.
- CLEAR: clearAccum=1, zeroError=1, exps=acq. clrCnt increments on symEn. On the symEn where clrCnt reaches CLEAR_SYMS-1 -> ACQ, clrCnt=0.
- ACQ: clearAccum=0, zeroError=0, exps=acq.
  - On each symEn: lockRun = demodLock ? lockRun+1 : 0, and acqTimer+1.
  - lockRun+1 >= max(dwellCount,1) with demodLock=1 -> TRACK.
  - Else acqTimeout!=0 and acqTimer+1 >= acqTimeout -> CLEAR, reacqCount+1.
  - If both conditions hold on the same symEn, TRACK wins.
- TRACK: clearAccum=0, zeroError=0, exps=trk, trackLock=1.
  - On each symEn: lossRun = demodLock ? 0 : lossRun+1.
  - lossRun+1 >= max(lossCount,1) -> CLEAR, reacqCount+1.
- All run counters and timers reset to 0 on every state entry. They saturate at all-ones and never wrap.
- reacqCount saturates at 255.
- enable=0 in any state -> IDLE on the next edge. This has priority over every other transition, including one on the same cycle.
- No state change without symEn, except enable-driven transitions.
- Limit ports and exponent inputs are sampled live. A change to trk exps while in TRACK appears on leadExp/lagExp the next cycle.
- reset asserted mid-operation -> reset values on the next edge regardless of symEn.

Test Plan:
- Reset with enable=1, symEn every 4 clk -> outputs hold reset values during reset. After release: CLEAR for exactly 4 symEn, then state=2, clearAccum=0, leadExp=acqLeadExp.
- ACQ, dwellCount=10, demodLock=1 for 9 symEn, 0 for 1, then 1 -> TRACK entered on the 10th locked symEn after the drop. leadExp/lagExp switch to trk values on that edge; trackLock=1.
- TRACK, lossCount=5, demodLock toggled 0x4/1x1 repeatedly -> no reacquire. Then 5 consecutive 0 -> CLEAR, reacqCount=1, clearAccum=1.
- ACQ, acqTimeout=20, demodLock=0 -> CLEAR after 20 symEn. Repeat 300 times -> reacqCount=255 (saturated).
- dwellCount=acqTimeout=8, demodLock=1 throughout ACQ -> TRACK (not CLEAR) on 8th symEn. dwellCount=0 -> TRACK on 1st locked symEn.
- In TRACK, drop enable for 1 cycle coincident with symEn meeting the loss condition -> IDLE (not CLEAR). Re-enable -> reacqCount=0, CLEAR entered.

Source files
------------

// File: rtl/multih_loop_acq_ctrl.sv
// Acquisition/track sequencer for the multi-h carrier loop.
// Selects loop gain exponents and clear controls from demod lock.
module multih_loop_acq_ctrl #(
  parameter int CLEAR_SYMS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             symEn,
  input  logic             enable,
  input  logic             demodLock,
  input  logic [4:0]       acqLeadExp,
  input  logic [4:0]       acqLagExp,
  input  logic [4:0]       trkLeadExp,
  input  logic [4:0]       trkLagExp,
  input  logic [CNT_W-1:0] dwellCount,
  input  logic [CNT_W-1:0] lossCount,
  input  logic [CNT_W-1:0] acqTimeout,
  output logic [4:0]       leadExp,
  output logic [4:0]       lagExp,
  output logic             clearAccum,
  output logic             zeroError,
  output logic [1:0]       state,
  output logic             trackLock,
  output logic [7:0]       reacqCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACQ   = 2'd2,
    TRACK = 2'd3
  } state_t;

  localparam logic [7:0]       CLR_LAST = 8'(CLEAR_SYMS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           st_q, st_n;
  logic [7:0]       clr_q, clr_n;
  logic [CNT_W-1:0] lock_q, lock_n;
  logic [CNT_W-1:0] acqt_q, acqt_n;
  logic [CNT_W-1:0] loss_q, loss_n;
  logic [7:0]       reacq_n;

  logic [4:0]       lead_d, lag_d;
  logic             clr_acc_d, zero_d, trk_d;

  // Compare limits one bit wider so a saturated run still exceeds them.
  logic [CNT_W:0]   lock_inc, acqt_inc, loss_inc;
  logic [CNT_W:0]   dwell_eff, loss_eff, tmo_w;

  assign lock_inc  = {1'b0, lock_q} + 1'b1;
  assign acqt_inc  = {1'b0, acqt_q} + 1'b1;
  assign loss_inc  = {1'b0, loss_q} + 1'b1;
  assign dwell_eff = (dwellCount == '0) ? (CNT_W+1)'(1)
                                        : {1'b0, dwellCount};
  assign loss_eff  = (lossCount == '0) ? (CNT_W+1)'(1)
                                       : {1'b0, lossCount};
  assign tmo_w     = {1'b0, acqTimeout};

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] reacq_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    st_n    = st_q;
    clr_n   = clr_q;
    lock_n  = lock_q;
    acqt_n  = acqt_q;
    loss_n  = loss_q;
    reacq_n = reacqCount;
    unique case (st_q)
      IDLE: begin
        if (enable) begin
          st_n    = CLEAR;
          reacq_n = 8'd0;
        end
      end
      CLEAR: begin
        if (symEn) begin
          if (clr_q >= CLR_LAST) st_n = ACQ;
          else clr_n = clr_q + 8'd1;
        end
      end
      ACQ: begin
        if (symEn) begin
          lock_n = demodLock ? sat_inc(lock_q) : '0;
          acqt_n = sat_inc(acqt_q);
          if (demodLock && lock_inc >= dwell_eff) begin
            st_n = TRACK;
          end else if (acqTimeout != '0 && acqt_inc >= tmo_w) begin
            st_n    = CLEAR;
            reacq_n = reacq_inc(reacqCount);
          end
        end
      end
      TRACK: begin
        if (symEn) begin
          loss_n = demodLock ? '0 : sat_inc(loss_q);
          if (!demodLock && loss_inc >= loss_eff) begin
            st_n    = CLEAR;
            reacq_n = reacq_inc(reacqCount);
          end
        end
      end
    endcase
    if (!enable) begin
      st_n    = IDLE;
      reacq_n = reacqCount;
    end
    if (st_n != st_q) begin
      clr_n  = '0;
      lock_n = '0;
      acqt_n = '0;
      loss_n = '0;
    end
  end

  always_comb begin
    trk_d     = (st_n == TRACK);
    clr_acc_d = (st_n == IDLE) || (st_n == CLEAR);
    zero_d    = clr_acc_d;
    lead_d    = trk_d ? trkLeadExp : acqLeadExp;
    lag_d     = trk_d ? trkLagExp  : acqLagExp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= IDLE;
      clr_q      <= '0;
      lock_q     <= '0;
      acqt_q     <= '0;
      loss_q     <= '0;
      reacqCount <= 8'd0;
      leadExp    <= 5'd0;
      lagExp     <= 5'd0;
      clearAccum <= 1'b1;
      zeroError  <= 1'b1;
      trackLock  <= 1'b0;
    end else begin
      st_q       <= st_n;
      clr_q      <= clr_n;
      lock_q     <= lock_n;
      acqt_q     <= acqt_n;
      loss_q     <= loss_n;
      reacqCount <= reacq_n;
      leadExp    <= lead_d;
      lagExp     <= lag_d;
      clearAccum <= clr_acc_d;
      zeroError  <= zero_d;
      trackLock  <= trk_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_multih_loop_acq_ctrl.sv
// Bench for multih_loop_acq_ctrl: directed table, corner
// sequences and random stimulus against a behavioural model.
module tb_multih_loop_acq_ctrl;

  localparam int CLEAR_SYMS = 4;
  localparam int CNT_W      = 16;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             symEn;
  logic             enable;
  logic             demodLock;
  logic [4:0]       acqLeadExp, acqLagExp;
  logic [4:0]       trkLeadExp, trkLagExp;
  logic [CNT_W-1:0] dwellCount, lossCount, acqTimeout;
  logic [4:0]       leadExp, lagExp;
  logic             clearAccum, zeroError, trackLock;
  logic [1:0]       state;
  logic [7:0]       reacqCount;

  multih_loop_acq_ctrl #(
    .CLEAR_SYMS(CLEAR_SYMS),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .symEn(symEn),
    .enable(enable),
    .demodLock(demodLock),
    .acqLeadExp(acqLeadExp),
    .acqLagExp(acqLagExp),
    .trkLeadExp(trkLeadExp),
    .trkLagExp(trkLagExp),
    .dwellCount(dwellCount),
    .lossCount(lossCount),
    .acqTimeout(acqTimeout),
    .leadExp(leadExp),
    .lagExp(lagExp),
    .clearAccum(clearAccum),
    .zeroError(zeroError),
    .state(state),
    .trackLock(trackLock),
    .reacqCount(reacqCount)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: state as a small integer, counters as ints.
  int m_st, m_clr, m_lock, m_acqt, m_loss, m_reacq;
  int m_lead, m_lag, m_clracc, m_trk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_update();
    int nxt;
    int d, l, run, t;
    if (reset) begin
      m_st = 0; m_clr = 0; m_lock = 0; m_acqt = 0; m_loss = 0;
      m_reacq = 0; m_lead = 0; m_lag = 0; m_clracc = 1; m_trk = 0;
      return;
    end
    nxt = m_st;
    if (!enable) begin
      nxt = 0;
    end else if (m_st == 0) begin
      nxt = 1;
      m_reacq = 0;
    end else if (symEn) begin
      if (m_st == 1) begin
        m_clr++;
        if (m_clr >= CLEAR_SYMS) nxt = 2;
      end else if (m_st == 2) begin
        d = (dwellCount == 0) ? 1 : int'(dwellCount);
        run = demodLock ? m_lock + 1 : 0;
        t = m_acqt + 1;
        if (demodLock && run >= d) nxt = 3;
        else if (acqTimeout != 0 && t >= int'(acqTimeout)) begin
          nxt = 1;
          m_reacq = imin(m_reacq + 1, 255);
        end
        m_lock = imin(run, CMAX);
        m_acqt = imin(t, CMAX);
      end else begin
        l = (lossCount == 0) ? 1 : int'(lossCount);
        run = demodLock ? 0 : m_loss + 1;
        if (!demodLock && run >= l) begin
          nxt = 1;
          m_reacq = imin(m_reacq + 1, 255);
        end
        m_loss = imin(run, CMAX);
      end
    end
    if (nxt != m_st) begin
      m_clr = 0; m_lock = 0; m_acqt = 0; m_loss = 0;
    end
    m_st = nxt;
    m_trk = (m_st == 3) ? 1 : 0;
    m_clracc = (m_st <= 1) ? 1 : 0;
    m_lead = m_trk ? int'(trkLeadExp) : int'(acqLeadExp);
    m_lag  = m_trk ? int'(trkLagExp)  : int'(acqLagExp);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", int'(state), m_st);
    chk("leadExp", int'(leadExp), m_lead);
    chk("lagExp", int'(lagExp), m_lag);
    chk("clearAccum", int'(clearAccum), m_clracc);
    chk("zeroError", int'(zeroError), m_clracc);
    chk("trackLock", int'(trackLock), m_trk);
    chk("reacqCount", int'(reacqCount), m_reacq);
  endtask

  task automatic step(input logic s);
    symEn = s;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic syms(input int n, input int gap);
    for (int j = 0; j < n; j++) begin
      for (int g = 1; g < gap; g++) step(1'b0);
      step(1'b1);
    end
  endtask

  typedef struct {
    logic lk;
    int   nsym;
    int   gap;
    int   dwell;
    int   loss;
    int   tmo;
    int   est;
    int   ereacq;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 3, 4, 10, 5, 0, 1, 0};
    tbl[1]  = '{1'b0, 1, 4, 10, 5, 0, 2, 0};
    tbl[2]  = '{1'b1, 9, 4, 10, 5, 0, 2, 0};
    tbl[3]  = '{1'b0, 1, 4, 10, 5, 0, 2, 0};
    tbl[4]  = '{1'b1, 9, 4, 10, 5, 0, 2, 0};
    tbl[5]  = '{1'b1, 1, 4, 10, 5, 0, 3, 0};
    tbl[6]  = '{1'b0, 4, 1, 10, 5, 0, 3, 0};
    tbl[7]  = '{1'b1, 1, 1, 10, 5, 0, 3, 0};
    tbl[8]  = '{1'b0, 4, 1, 10, 5, 0, 3, 0};
    tbl[9]  = '{1'b1, 1, 1, 10, 5, 0, 3, 0};
    tbl[10] = '{1'b0, 5, 1, 10, 5, 0, 1, 1};
    tbl[11] = '{1'b0, 4, 1, 10, 5, 20, 2, 1};
    tbl[12] = '{1'b0, 19, 1, 10, 5, 20, 2, 1};
    tbl[13] = '{1'b0, 1, 1, 10, 5, 20, 1, 2};

    reset = 1'b1; symEn = 1'b0; enable = 1'b1; demodLock = 1'b0;
    acqLeadExp = 5'd12; acqLagExp = 5'd20;
    trkLeadExp = 5'd3;  trkLagExp = 5'd7;
    dwellCount = 16'd10; lossCount = 16'd5; acqTimeout = 16'd0;

    for (int i = 0; i < 8; i++) step((i % 4) == 3);
    chk("rst_lead", int'(leadExp), 0);
    chk("rst_clear", int'(clearAccum), 1);
    reset = 1'b0;
    step(1'b0);
    chk("leave_idle", int'(state), 1);

    for (int i = 0; i < 14; i++) begin
      demodLock  = tbl[i].lk;
      dwellCount = CNT_W'(tbl[i].dwell);
      lossCount  = CNT_W'(tbl[i].loss);
      acqTimeout = CNT_W'(tbl[i].tmo);
      syms(tbl[i].nsym, tbl[i].gap);
      chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].est);
      chk($sformatf("tbl%0d_reacq", i), int'(reacqCount),
          tbl[i].ereacq);
      if (i == 1) chk("acq_lead", int'(leadExp), 12);
      if (i == 5) chk("trk_lead", int'(leadExp), 3);
    end

    for (int r = 0; r < 300; r++) syms(CLEAR_SYMS + 20, 1);
    chk("sat_state", int'(state), 1);
    chk("sat_reacq", int'(reacqCount), 255);

    dwellCount = 16'd8; acqTimeout = 16'd8; demodLock = 1'b1;
    syms(CLEAR_SYMS, 1);
    chk("tie_acq", int'(state), 2);
    syms(7, 1);
    chk("tie_7", int'(state), 2);
    syms(1, 1);
    chk("tie_track", int'(state), 3);

    acqTimeout = 16'd0; lossCount = 16'd1; demodLock = 1'b0;
    syms(1, 1);
    chk("loss1_clear", int'(state), 1);
    dwellCount = 16'd0; demodLock = 1'b1;
    syms(CLEAR_SYMS, 1);
    syms(1, 1);
    chk("dwell0_track", int'(state), 3);

    demodLock = 1'b0; enable = 1'b0;
    step(1'b1);
    chk("en_prio_idle", int'(state), 0);
    chk("en_prio_reacq", int'(reacqCount), 255);
    enable = 1'b1;
    step(1'b0);
    chk("reen_clear", int'(state), 1);
    chk("reen_reacq", int'(reacqCount), 0);

    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      enable     = ($urandom_range(0, 99) != 0);
      demodLock  = ($urandom_range(0, 3) != 0);
      dwellCount = CNT_W'($urandom_range(0, 6));
      lossCount  = CNT_W'($urandom_range(0, 4));
      acqTimeout = CNT_W'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        acqLeadExp = 5'($urandom); acqLagExp = 5'($urandom);
        trkLeadExp = 5'($urandom); trkLagExp = 5'($urandom);
      end
      step(1'($urandom_range(0, 1)));
    end
    reset = 1'b1;
    step(1'b0);
    chk("final_reset", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
